cfg_chain_loader: RTL

//   Peripheral-bus master for the reconfigurable module's configuration shift chains.
//   The CPU selects a chain, sets a bit count, and writes 16-bit data words. The block

---
 rtl/cfg_chain_loader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - peripheral-bus master that serialises 16-bit words onto configuration shift chains
//
// Optional build macro: CFG_LOADER_AUTOCOUNT_EN
//   When defined, a DATA write while COUNT==0 shifts a full 16-bit chunk and
//   COUNT stays at 0. When undefined, such a write is rejected and sets Err.
//
// Register map (word offset from BaseAddr):
//   0 CTRL   [0] Mode, [7:4] Sel, [15] Busy (read-only)
//   1 COUNT  bits remaining, decremented once per shifted bit
//   2 DATA   write starts a chunk, read returns the captured word
//   3 STATUS [0] Busy, [1] Err (sticky, write 1 to clear)

module cfg_chain_loader #(
  parameter int BaseAddr = 'h0180,
  parameter int NumCfgs  = 4
) (
  input  logic               Clk_i,
  input  logic               Reset_n_i,
  input  logic [13:0]        PerAddr_i,
  input  logic [15:0]        PerDIn_i,
  input  logic [1:0]         PerWr_i,
  input  logic               PerEn_i,
  output logic [15:0]        PerDOut_o,
  output logic               CfgMode_o,
  output logic [NumCfgs-1:0] CfgClk_o,
  output logic [NumCfgs-1:0] CfgShift_o,
  output logic               CfgDataOut_o,
  input  logic [NumCfgs-1:0] CfgDataIn_i
);

  // Upper twelve bits of the block's word address; the low two bits pick the register.
  localparam logic [11:0] BaseWord = 12'(BaseAddr >> 2);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2
  } state_t;

  state_t state;
  state_t nextState;

  logic        modeReg;
  logic [3:0]  selReg;
  logic [15:0] countReg;
  logic        errReg;
  logic [15:0] txSR;
  logic [15:0] rxSR;
  logic [4:0]  bitCnt;

  logic               hit;
  logic               wrAcc;
  logic               rdAcc;
  logic               wrCtrl;
  logic               wrCount;
  logic               wrData;
  logic               wrStatus;
  logic               busy;
  logic               selValid;
  logic               countOk;
  logic               chunkOk;
  logic               startChunk;
  logic               errSet;
  logic               errClr;
  logic [4:0]         chunkLen;
  logic               lastBit;
  logic               shiftEn;
  logic               clkEn;
  logic               dataOut;
  logic [NumCfgs-1:0] selOneHot;
  logic               rxIn;

  // Address decode: only full-word writes act, reads need both enables low.
  assign hit      = PerEn_i && (PerAddr_i[13:2] == BaseWord);
  assign wrAcc    = hit && (PerWr_i == 2'b11);
  assign rdAcc    = hit && (PerWr_i == 2'b00);
  assign wrCtrl   = wrAcc && (PerAddr_i[1:0] == 2'd0);
  assign wrCount  = wrAcc && (PerAddr_i[1:0] == 2'd1);
  assign wrData   = wrAcc && (PerAddr_i[1:0] == 2'd2);
  assign wrStatus = wrAcc && (PerAddr_i[1:0] == 2'd3);

  assign busy     = (state != StIdle);
  assign selValid = (int'(selReg) < NumCfgs);

`ifdef CFG_LOADER_AUTOCOUNT_EN
  assign countOk = 1'b1;
`else
  assign countOk = (countReg != 16'd0);
`endif

  // A chunk may start only in config mode, on an existing chain, with bits to send.
  assign chunkOk    = modeReg && selValid && countOk;
  assign startChunk = wrData && !busy && chunkOk;

  // Err is raised by any blocked write: a config write during a chunk or a refused start.
  assign errSet = (busy && (wrCtrl || wrCount || wrData)) || (wrData && !busy && !chunkOk);
  assign errClr = wrStatus && PerDIn_i[1];

  // COUNT==0 only reaches here in autocount builds, where it means a full word.
  assign chunkLen = ((countReg == 16'd0) || (countReg >= 16'd16)) ? 5'd16 : countReg[4:0];
  assign lastBit  = (bitCnt == 5'd1);

  // One-hot decode of the selected chain; an out-of-range Sel selects nothing.
  always_comb begin
    selOneHot = '0;
    for (int i = 0; i < NumCfgs; i++) begin
      selOneHot[i] = (selReg == 4'(i));
    end
  end

  // Serial bit returning from the selected chain's tail.
  assign rxIn = |(CfgDataIn_i & selOneHot);

  // State register; reset drops straight to idle so no strobe survives a reset.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and chain strobe generation: each bit is a setup cycle then a strobe cycle.
  always_comb begin
    nextState = state;
    shiftEn   = 1'b0;
    clkEn     = 1'b0;
    dataOut   = 1'b0;
    case (state)
      StIdle: begin
        if (startChunk) begin
          nextState = StSetup;
        end
      end
      StSetup: begin
        shiftEn   = 1'b1;
        dataOut   = txSR[0];
        nextState = StStrobe;
      end
      StStrobe: begin
        shiftEn   = 1'b1;
        clkEn     = 1'b1;
        dataOut   = txSR[0];
        nextState = lastBit ? StIdle : StSetup;
      end
      default: begin
        nextState = StIdle;
      end
    endcase
  end

  assign CfgShift_o   = shiftEn ? selOneHot : '0;
  assign CfgClk_o     = clkEn ? selOneHot : '0;
  assign CfgDataOut_o = dataOut;
  assign CfgMode_o    = modeReg;

  // CTRL fields; frozen while a chunk is in flight.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      modeReg <= 1'b0;
      selReg  <= 4'd0;
    end else if (wrCtrl && !busy) begin
      modeReg <= PerDIn_i[0];
      selReg  <= PerDIn_i[7:4];
    end
  end

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      errReg <= 1'b0;
    end else if (errSet) begin
      errReg <= 1'b1;
    end else if (errClr) begin
      errReg <= 1'b0;
    end
  end

  // Bit counter seen by software: loaded when idle, decremented on each strobe, never wraps.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      countReg <= 16'd0;
    end else if (wrCount && !busy) begin
      countReg <= PerDIn_i;
    end else if ((state == StStrobe) && (countReg != 16'd0)) begin
      countReg <= countReg - 16'd1;
    end
  end

  // Transmit/receive shift registers: TX shifts out LSB first, RX fills from the MSB end.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      txSR   <= 16'd0;
      rxSR   <= 16'd0;
      bitCnt <= 5'd0;
    end else if (startChunk) begin
      txSR   <= PerDIn_i;
      rxSR   <= 16'd0;
      bitCnt <= chunkLen;
    end else if (state == StStrobe) begin
      txSR   <= {1'b0, txSR[15:1]};
      rxSR   <= {rxIn, rxSR[15:1]};
      bitCnt <= bitCnt - 5'd1;
    end
  end

  // Read mux onto the OR-bus; drives zero whenever this block is not being read.
  always_comb begin
    PerDOut_o = 16'd0;
    if (rdAcc) begin
      case (PerAddr_i[1:0])
        2'd0:    PerDOut_o = {busy, 7'd0, selReg, 3'd0, modeReg};
        2'd1:    PerDOut_o = countReg;
        2'd2:    PerDOut_o = rxSR;
        default: PerDOut_o = {14'd0, errReg, busy};
      endcase
    end
  end

endmodule
